// File: rtl/stage_ex_pkg.sv
// ex_pkg: shared constants for the execute stage.
//   - EX_DATA_W : default datapath width
//   - ALU_*     : ALUOp encodings (codes 10..15 are unused and produce 0)
//   - ex_state_t: multiply sequencer states
package ex_pkg;

    localparam int EX_DATA_W = 32;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_NOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SUB = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;
    localparam logic [3:0] ALU_MUL = 4'd9;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_MUL  = 2'd1,
        EX_DONE = 2'd2
    } ex_state_t;

endpackage

// File: rtl/stage_ex_mul.sv
// mul_iterative: shift-add multiplier, one multiplier bit per clock.
// Ports:
//   clk, srst : clock, synchronous active-high reset
//   abort     : synchronous abort, returns to idle and discards the product
//   start     : sampled only while idle; latches a and b
//   a, b      : operands
//   idle      : sequencer is waiting for start
//   busy      : a shift-add step happens this cycle
//   done      : product is final this cycle (one cycle only)
//   product   : low DATA_W bits of a*b
module mul_iterative
    import ex_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              abort,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              idle,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_W - 1);

    ex_state_t         state_reg;
    logic [CW-1:0]     count_reg;
    logic [DATA_W-1:0] mcand_reg;
    logic [DATA_W-1:0] mplier_reg;
    logic [DATA_W-1:0] acc_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg  <= EX_IDLE;
            count_reg  <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
        end else if (abort) begin
            state_reg <= EX_IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                EX_IDLE: begin
                    if (start) begin
                        mcand_reg  <= a;
                        mplier_reg <= b;
                        acc_reg    <= '0;
                        count_reg  <= '0;
                        state_reg  <= EX_MUL;
                    end
                end
                EX_MUL: begin
                    // Multiplicand walks left while multiplier bits are
                    // consumed from the LSB; bits shifted past DATA_W are
                    // not needed for the low half of the product.
                    if (mplier_reg[0]) begin
                        acc_reg <= acc_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + CW'(1);
                    if (count_reg == LAST_STEP) begin
                        state_reg <= EX_DONE;
                    end
                end
                EX_DONE: begin
                    state_reg <= EX_IDLE;
                end
                default: begin
                    state_reg <= EX_IDLE;
                end
            endcase
        end
    end

    assign idle    = (state_reg == EX_IDLE);
    assign busy    = (state_reg == EX_MUL);
    assign done    = (state_reg == EX_DONE);
    assign product = acc_reg;

endmodule

// File: rtl/stage_ex.sv
// stage_ex: MIPS execute stage plus the EX/MEM pipeline register.
// Ports:
//   Clk, Rst, Flush        : clock, sync active-high reset, bubble/abort
//   InValid + ID/EX fields : operands, immediate, PC+4, ALUOp, muxes, Rt/Rd,
//                            pass-through control (*_in)
//   Stall                  : combinational hold request to upstream stages
//   OutValid + EX/MEM regs : ALUResult, Zero, ALUAddResult, ReadData2_out,
//                            WriteReg, MemWrite/MemRead/Branch/MemtoReg/RegWrite
// Single-cycle ALU ops complete in one edge; MUL occupies the stage for
// DATA_W+2 cycles (start, DATA_W steps, done) with Stall high until done.
module stage_ex
    import ex_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              InValid,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic [DATA_W-1:0] SignExtImm,
    input  logic [DATA_W-1:0] PCAddResult,
    input  logic [3:0]        ALUOp,
    input  logic              ALUSrc,
    input  logic              RegDst,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Rd,
    input  logic              MemWrite_in,
    input  logic              MemRead_in,
    input  logic              Branch_in,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    output logic              Stall,
    output logic              OutValid,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero,
    output logic [DATA_W-1:0] ALUAddResult,
    output logic [DATA_W-1:0] ReadData2_out,
    output logic [4:0]        WriteReg,
    output logic              MemWrite,
    output logic              MemRead,
    output logic              Branch,
    output logic              MemtoReg,
    output logic              RegWrite
);

    logic [DATA_W-1:0] op_b;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] branch_target;
    logic [4:0]        write_reg;
    logic              is_mul;
    logic              mul_start;
    logic              mul_idle;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign op_b          = ALUSrc ? SignExtImm : ReadData2;
    assign shamt         = SignExtImm[10:6];
    assign write_reg     = RegDst ? Rd : Rt;
    assign branch_target = PCAddResult + (SignExtImm << 2);

    // Stall is a pure function of sequencer state and ID/EX control so the
    // upstream hold never depends on datapath timing.
    assign is_mul    = InValid && (ALUOp == ALU_MUL);
    assign mul_start = is_mul && !Flush && !Rst;
    assign Stall     = !Rst && !Flush && (mul_busy || (mul_idle && is_mul));

    mul_iterative #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (Clk),
        .srst    (Rst),
        .abort   (Flush),
        .start   (mul_start),
        .a       (ReadData1),
        .b       (op_b),
        .idle    (mul_idle),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_result = '0;
        case (ALUOp)
            ALU_AND: alu_result = ReadData1 & op_b;
            ALU_OR:  alu_result = ReadData1 | op_b;
            ALU_ADD: alu_result = ReadData1 + op_b;
            ALU_XOR: alu_result = ReadData1 ^ op_b;
            ALU_NOR: alu_result = ~(ReadData1 | op_b);
            ALU_SLL: alu_result = op_b << shamt;
            ALU_SRL: alu_result = op_b >> shamt;
            ALU_SUB: alu_result = ReadData1 - op_b;
            ALU_SLT: alu_result[0] = ($signed(ReadData1) < $signed(op_b));
            ALU_MUL: alu_result = mul_product;
            default: alu_result = '0;
        endcase
    end

    // While the multiplier reports done the held MUL instruction is what
    // EX/MEM captures, so the product always takes the result path then.
    assign ex_result = mul_done ? mul_product : alu_result;

    // Pass-through control, qualified by InValid one bit at a time.
    logic [4:0] ctrl_in;
    logic [4:0] ctrl_gated;
    assign ctrl_in = {MemWrite_in, MemRead_in, Branch_in, MemtoReg_in, RegWrite_in};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_ctrl_gate
            assign ctrl_gated[gi] = ctrl_in[gi] & InValid;
        end
    endgenerate

    logic [DATA_W-1:0] result_reg;
    logic              zero_reg;
    logic [DATA_W-1:0] target_reg;
    logic [DATA_W-1:0] store_reg;
    logic [4:0]        wreg_reg;
    logic [4:0]        ctrl_reg;
    logic              valid_reg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            result_reg <= '0;
            zero_reg   <= 1'b0;
            target_reg <= '0;
            store_reg  <= '0;
            wreg_reg   <= '0;
            ctrl_reg   <= '0;
            valid_reg  <= 1'b0;
        end else if (Flush || Stall) begin
            // Bubble: only control and valid drop; data fields hold.
            ctrl_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            result_reg <= ex_result;
            zero_reg   <= (ex_result == '0);
            target_reg <= branch_target;
            store_reg  <= ReadData2;
            wreg_reg   <= write_reg;
            ctrl_reg   <= ctrl_gated;
            valid_reg  <= InValid;
        end
    end

    assign ALUResult     = result_reg;
    assign Zero          = zero_reg;
    assign ALUAddResult  = target_reg;
    assign ReadData2_out = store_reg;
    assign WriteReg      = wreg_reg;
    assign OutValid      = valid_reg;
    assign MemWrite      = ctrl_reg[4];
    assign MemRead       = ctrl_reg[3];
    assign Branch        = ctrl_reg[2];
    assign MemtoReg      = ctrl_reg[1];
    assign RegWrite      = ctrl_reg[0];

endmodule
